spi_slave_ctrl: RTL and testbench

//  Parametrised SPI slave front end: deserialises MOSI command+data frames into rx_data/rx_valid
//  for the memory-side block, and serialises tx_data onto MISO for read-data transactions.

---
 rtl/spi_slave_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises MOSI {cmd, payload} frames and serialises read data onto MISO.
// Optional odd-parity framing is enabled with `define SPI_SLV_PARITY_EN.
module spi_slave_ctrl #(
    parameter int DATA_W = 8,
    parameter int CMD_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ss_n,
    input  logic                      MOSI,
    output logic                      MISO,
    output logic [CMD_W+DATA_W-1:0]   rx_data,
    output logic                      rx_valid,
    input  logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_valid,
    output logic                      parity_err
);

    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int CW      = $clog2(FRAME_W + 2);

`ifdef SPI_SLV_PARITY_EN
    // The whole frame is held in the shifter while the trailing parity bit is sampled.
    localparam int             SH_W    = FRAME_W;
    localparam logic [CW-1:0]  LAST_RX = CW'(FRAME_W);
`else
    localparam int             SH_W    = FRAME_W - 1;
    localparam logic [CW-1:0]  LAST_RX = CW'(FRAME_W - 1);
`endif
    localparam logic [CW-1:0]  DATA_CNT = CW'(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX_WAIT,
        TX_SHIFT
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SH_W-1:0]      rx_sh_q, rx_sh_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rd_done_q, rd_done_d;
    logic [DATA_W-1:0]    tx_sh_q, tx_sh_d;
    logic                 miso_q, miso_d;
    logic [FRAME_W-1:0]   frame_w;
    logic                 par_ok;

`ifdef SPI_SLV_PARITY_EN
    logic                 perr_q, perr_d;
    logic                 tx_par_q, tx_par_d;

    assign frame_w = rx_sh_q;
    assign par_ok  = ^{rx_sh_q, MOSI};
`else
    assign frame_w = {rx_sh_q, MOSI};
    assign par_ok  = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rd_done_d  = rd_done_q;
        tx_sh_d    = tx_sh_q;
        miso_d     = 1'b0;
`ifdef SPI_SLV_PARITY_EN
        perr_d     = 1'b0;
        tx_par_d   = tx_par_q;
`endif
        if (ss_n) begin
            // Deselect drops any partial frame; the read-address flag survives.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = CHK_CMD;
                    cnt_d   = '0;
                end
                CHK_CMD: begin
                    rx_sh_d = SH_W'(MOSI);
                    cnt_d   = CW'(1);
                    if (!MOSI)         state_d = WRITE;
                    else if (rd_done_q) state_d = READ_DATA;
                    else               state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    rx_sh_d = SH_W'({rx_sh_q, MOSI});
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_RX) begin
                        cnt_d   = '0;
                        state_d = CHK_CMD;
                        if (par_ok) begin
                            rx_data_d  = frame_w;
                            rx_valid_d = 1'b1;
                            if (state_q == READ_ADD)  rd_done_d = 1'b1;
                            if (state_q == READ_DATA) state_d   = TX_WAIT;
                        end
`ifdef SPI_SLV_PARITY_EN
                        else begin
                            perr_d = 1'b1;
                        end
`endif
                    end
                end
                TX_WAIT: begin
                    if (tx_valid) begin
                        miso_d  = tx_data[DATA_W-1];
                        tx_sh_d = tx_data << 1;
                        cnt_d   = CW'(1);
                        state_d = TX_SHIFT;
`ifdef SPI_SLV_PARITY_EN
                        tx_par_d = ~^tx_data;
`endif
                    end
                end
                TX_SHIFT: begin
                    // cnt_q counts bits already presented on MISO.
                    if (cnt_q < DATA_CNT) begin
                        miso_d  = tx_sh_q[DATA_W-1];
                        tx_sh_d = tx_sh_q << 1;
                        cnt_d   = cnt_q + 1'b1;
                    end
`ifdef SPI_SLV_PARITY_EN
                    else if (cnt_q == DATA_CNT) begin
                        miso_d = tx_par_q;
                        cnt_d  = cnt_q + 1'b1;
                    end
`endif
                    else begin
                        cnt_d     = '0;
                        state_d   = CHK_CMD;
                        rd_done_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
            tx_sh_q    <= '0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rd_done_q  <= rd_done_d;
            tx_sh_q    <= tx_sh_d;
            miso_q     <= miso_d;
        end
    end

`ifdef SPI_SLV_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q   <= 1'b0;
            tx_par_q <= 1'b0;
        end else begin
            perr_q   <= perr_d;
            tx_par_q <= tx_par_d;
        end
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl: table-driven write frames plus hand-written
// read/TX, abort and reset sequences; received frames are checked through a scoreboard queue.
module tb_spi_slave_ctrl;

    localparam int DATA_W  = 8;
    localparam int CMD_W   = 2;
    localparam int FRAME_W = CMD_W + DATA_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               ss_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;
    logic               parity_err;

    int chk_cnt   = 0;
    int pass_cnt  = 0;
    int perr_seen = 0;
    int exp_perr  = 0;
    logic prev_valid = 1'b0;
    logic [FRAME_W-1:0] exp_q[$];

    typedef struct {
        logic [FRAME_W-1:0] frame;
        int                 nbits;
        bit                 gap;
        bit                 exp_valid;
        logic [FRAME_W-1:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    spi_slave_ctrl #(.DATA_W(DATA_W), .CMD_W(CMD_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ss_n       (ss_n),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .parity_err (parity_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard consumer: every rx_valid pulse must match the oldest pushed frame.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (prev_valid) check("rx_valid_consecutive", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                check("rx_valid_unexpected", {31'd0, rx_valid}, 32'd0);
            end else begin
                logic [FRAME_W-1:0] e;
                e = exp_q.pop_front();
                $display("rx frame got %03h expected %03h", rx_data, e);
                check("rx_data", 32'(rx_data), 32'(e));
            end
        end
        if (parity_err === 1'b1) perr_seen++;
        prev_valid <= (rx_valid === 1'b1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic open_ss();
        ss_n = 1'b1;
        tick();
        ss_n = 1'b0;
        tick();
    endtask

    task automatic send_range(input logic [FRAME_W-1:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            MOSI = f[i];
            tick();
        end
    endtask

    task automatic send_par(input logic [FRAME_W-1:0] f);
`ifdef SPI_SLV_PARITY_EN
        MOSI = ~^f;
        tick();
`else
        MOSI = 1'b0;
        if (f === 'x) tick();
`endif
    endtask

    task automatic send_frame(input logic [FRAME_W-1:0] f);
        send_range(f, FRAME_W - 1, 0);
        send_par(f);
    endtask

    task automatic check_tx(input logic [DATA_W-1:0] d);
        MOSI = 1'b1;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            check("miso_bit", {31'd0, MISO}, {31'd0, d[i]});
            tick();
        end
`ifdef SPI_SLV_PARITY_EN
        check("miso_parity", {31'd0, MISO}, {31'd0, ~^d});
        tick();
`endif
        check("miso_after_tx", {31'd0, MISO}, 32'd0);
        $display("tx burst %02h done", d);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{10'h0A5, FRAME_W, 1'b1, 1'b1, 10'h0A5};
        vecs[1] = '{10'h1C3, FRAME_W, 1'b0, 1'b1, 10'h1C3};
        vecs[2] = '{10'h0FF, FRAME_W, 1'b0, 1'b1, 10'h0FF};
        vecs[3] = '{10'h155, FRAME_W, 1'b0, 1'b1, 10'h155};
        vecs[4] = '{10'h0A5, 5,       1'b0, 1'b0, 10'h000};
        vecs[5] = '{10'h0F0, FRAME_W, 1'b1, 1'b1, 10'h0F0};
        vecs[6] = '{10'h13C, FRAME_W, 1'b0, 1'b1, 10'h13C};

        rst = 1'b1; ss_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
        repeat (3) tick();
        check("reset_miso",     {31'd0, MISO},       32'd0);
        check("reset_rx_valid", {31'd0, rx_valid},   32'd0);
        check("reset_rx_data",  32'(rx_data),        32'd0);
        check("reset_perr",     {31'd0, parity_err}, 32'd0);
        rst = 1'b0;
        tick();

        // Write frames: back-to-back, aborted, and after reselect.
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].gap) open_ss();
            if (vecs[v].exp_valid) exp_q.push_back(vecs[v].exp_data);
            if (vecs[v].nbits == FRAME_W) begin
                send_frame(vecs[v].frame);
            end else begin
                send_range(vecs[v].frame, FRAME_W - 1, FRAME_W - vecs[v].nbits);
                ss_n = 1'b1;
                tick();
            end
        end
        ss_n = 1'b1;
        repeat (3) tick();
        check("rx_data_hold", 32'(rx_data), 32'h13C);

        // Read address, reselect, read data, then TX burst of B6.
        open_ss();
        exp_q.push_back(10'h20F);
        send_frame(10'h20F);
        open_ss();
        exp_q.push_back(10'h300);
        send_frame(10'h300);
        check("miso_tx_wait", {31'd0, MISO}, 32'd0);
        tx_data = 8'hB6; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0; tx_data = 8'h00;
        check_tx(8'hB6);
        // Read-address flag cleared by the burst: next read goes to READ_ADD, write follows.
        exp_q.push_back(10'h3C3);
        send_frame(10'h3C3);
        exp_q.push_back(10'h055);
        send_frame(10'h055);

        // Read data with stray tx_valid during reception and a 3-cycle wait.
        exp_q.push_back(10'h2AA);
        send_range(10'h2AA, 9, 6);
        tx_valid = 1'b1; tx_data = 8'hFF;
        send_range(10'h2AA, 5, 5);
        tx_valid = 1'b0; tx_data = 8'h00;
        send_range(10'h2AA, 4, 0);
        send_par(10'h2AA);
        for (int w = 0; w < 3; w++) begin
            check("miso_wait_low", {31'd0, MISO}, 32'd0);
            tick();
        end
        tx_data = 8'h5A; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check_tx(8'h5A);
        exp_q.push_back(10'h0C3);
        send_frame(10'h0C3);

        // Set the read-address flag, then reset asynchronously in the middle of a write frame.
        exp_q.push_back(10'h3C3);
        send_frame(10'h3C3);
        open_ss();
        send_range(10'h0A5, 9, 5);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_miso",     {31'd0, MISO},     32'd0);
        check("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_mid_rx_data",  32'(rx_data),     32'd0);
        repeat (2) tick();
        rst = 1'b0;
        send_range(10'h0A5, 4, 0);
        ss_n = 1'b1;
        repeat (2) tick();
        // Reset must have cleared the read-address flag: 2C3 is an address frame.
        open_ss();
        exp_q.push_back(10'h2C3);
        send_frame(10'h2C3);
        exp_q.push_back(10'h011);
        send_frame(10'h011);

`ifdef SPI_SLV_PARITY_EN
        send_range(10'h001, 9, 0);
        MOSI = 1'b1;
        tick();
        check("perr_pulse",    {31'd0, parity_err}, 32'd1);
        check("perr_no_valid", {31'd0, rx_valid},   32'd0);
        exp_perr = 1;
        exp_q.push_back(10'h001);
        send_frame(10'h001);
`endif

        ss_n = 1'b1;
        repeat (4) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("parity_err_count", 32'(perr_seen), 32'(exp_perr));
        check("final_miso", {31'd0, MISO}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
